serial_eq_cmp: RTL and testbench
================================

SERIAL_EQ_CMP -- requirements
Module: serial_eq_cmp

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of bit pairs per compared word (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a new word comparison.
REQ-005 in_valid  input  1  x/y bit pair is present this cycle.
REQ-006 x  input  1  serial bit of operand X, LSB first.
REQ-007 y  input  1  serial bit of operand Y, LSB first.
REQ-008 in_ready  output  1  block accepts a bit pair this cycle.
REQ-009 busy  output  1  comparison in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 equal  output  1  all N pairs matched (x XNOR y = 1 for every bit).
REQ-012 mismatches  output  clog2(N+1)  count of bit positions where x != y.
REQ-013 first_diff  output  clog2(N)  index of lowest mismatching bit; 0 when equal=1.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE, encoded in a registered state variable.
REQ-015 IDLE: in_ready=0, busy=0; start=1 at a rising edge SHALL move to RUN and clear bit index, working mismatch count, working first-diff and found flag.
REQ-016 RUN: in_ready=1, busy=1; a pair is accepted on each edge where in_valid=1; in_valid=0 SHALL leave all working state unchanged.
REQ-017 Per accepted pair, eq = x XNOR y; if eq=0, working count SHALL increment by 1, and if found flag is 0, working first-diff SHALL load the current bit index and found flag SHALL set.
REQ-018 Bit index SHALL increment by 1 per accepted pair, counting 0..N-1; no wrap occurs inside a word.
REQ-019 The edge accepting bit N-1 SHALL move to DONE and register equal, mismatches, first_diff, including the contribution of bit N-1.
REQ-020 DONE: done=1 for exactly one cycle, in_ready=0, busy=0; next edge SHALL return to IDLE unconditionally.
REQ-021 equal, mismatches, first_diff SHALL hold their values from DONE until the next DONE or reset; they SHALL NOT change during IDLE or RUN.
REQ-022 start SHALL be ignored in RUN and DONE; it is sampled only in IDLE.
REQ-023 x and y SHALL be ignored whenever in_ready=0 or in_valid=0.
REQ-024 Latency: done SHALL be asserted in the cycle immediately after the edge accepting bit N-1; minimum word time is N+2 cycles including start.
REQ-025 mismatches SHALL saturate at N by construction (maximum N accepted pairs); no overflow is possible.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and in_ready=0, busy=0, done=0, equal=0, mismatches=0, first_diff=0, and clear all working registers.
REQ-027 Reset asserted mid-word SHALL abort the comparison with no done pulse; the partial result SHALL be discarded.
REQ-028 After rst_n deasserts, the first start SHALL begin a clean comparison.

Verification (N=8)
REQ-029 Start; stream X=8'hA5, Y=8'hA5, in_valid held high -> done one cycle after 8th beat, equal=1, mismatches=0, first_diff=0.
REQ-030 X=8'h00, Y=8'hFF -> equal=0, mismatches=8, first_diff=0.
REQ-031 X=8'h10, Y=8'h00 -> equal=0, mismatches=1, first_diff=4.
REQ-032 REQ-029 stimulus with in_valid low on alternate cycles -> identical results; done delayed by the number of idle cycles.
REQ-033 rst_n pulsed low after 4 accepted beats -> all outputs 0, no done; a following start with X=Y=8'h3C -> equal=1, mismatches=0.
REQ-034 start pulsed during RUN at bit 3 of X=8'h01, Y=8'h03 -> ignored; result equal=0, mismatches=1, first_diff=1.

Source files
------------

// File: rtl/serial_eq_cmp.sv
// ---------------------------------------------------------------------------
// serial_eq_cmp
//
// Compares two N-bit operands delivered serially, one x/y bit pair per
// accepted beat, LSB first. After the N-th pair it reports whether the words
// are equal, how many bit positions differ, and the index of the lowest
// differing bit. Results are registered and held until the next word
// completes or reset.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a new comparison (sampled only in IDLE)
//   in_valid   : an x/y pair is present this cycle
//   x, y       : serial operand bits, LSB first
//   in_ready   : a pair is accepted this cycle when in_valid is also high
//   busy       : comparison in progress
//   done       : one-cycle pulse, results valid
//   equal      : every pair matched
//   mismatches : number of differing bit positions (0..N)
//   first_diff : lowest differing bit index, 0 when equal
// ---------------------------------------------------------------------------
module serial_eq_cmp #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic                     x,
  input  logic                     y,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     equal,
  output logic [$clog2(N+1)-1:0]   mismatches,
  output logic [$clog2(N)-1:0]     first_diff
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;

  // Working registers for the word in flight.
  logic [IW-1:0]   bit_idx;
  logic [CW-1:0]   cnt, cnt_next;
  logic [IW-1:0]   fd, fd_next;
  logic            found, found_next;

  logic            accept;
  logic            last_bit;
  logic            diff;

  assign accept   = in_ready & in_valid;
  assign last_bit = (bit_idx == IW'(N - 1));
  assign diff     = x ^ y;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state and status outputs
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-pair update of the working count and first-difference capture
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_next   = cnt;
    fd_next    = fd;
    found_next = found;
    if (diff) begin
      // At most N pairs are accepted per word, so the count never exceeds N.
      cnt_next = cnt + CW'(1);
      if (!found) begin
        fd_next    = bit_idx;
        found_next = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Working and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx    <= '0;
      cnt        <= '0;
      fd         <= '0;
      found      <= 1'b0;
      equal      <= 1'b0;
      mismatches <= '0;
      first_diff <= '0;
    end else if (state == IDLE && start) begin
      bit_idx <= '0;
      cnt     <= '0;
      fd      <= '0;
      found   <= 1'b0;
    end else if (accept) begin
      bit_idx <= bit_idx + IW'(1);
      cnt     <= cnt_next;
      fd      <= fd_next;
      found   <= found_next;
      // Results are loaded from the next-values so bit N-1 is included.
      // fd_next stays 0 for an all-matching word, giving first_diff = 0.
      if (last_bit) begin
        equal      <= (cnt_next == '0);
        mismatches <= cnt_next;
        first_diff <= fd_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_eq_cmp.sv
// ---------------------------------------------------------------------------
// tb_serial_eq_cmp
//
// Self-checking bench for serial_eq_cmp (N = 8). Directed vectors from a
// table, a mid-word reset sequence, then random words checked against a
// word-level reference model (XOR, popcount, lowest set bit).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_eq_cmp;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          x = 1'b0;
  logic          y = 1'b0;
  logic          in_ready, busy, done, equal;
  logic [CW-1:0] mismatches;
  logic [IW-1:0] first_diff;

  int checks = 0;
  int errors = 0;

  // Results the DUT is expected to be holding between words.
  logic hold_eq = 1'b0;
  int   hold_mm = 0;
  int   hold_fd = 0;

  always #5 clk = ~clk;

  serial_eq_cmp #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .x          (x),
    .y          (y),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .mismatches (mismatches),
    .first_diff (first_diff)
  );

  typedef struct {
    string        name;
    logic [N-1:0] xw;
    logic [N-1:0] yw;
    bit           gaps;      // in_valid low on alternate cycles
    int           start_at;  // beat at which start is re-pulsed, -1 for none
    bit           exp_eq;
    int           exp_mm;
    int           exp_fd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Word-level reference: differences are the set bits of x ^ y.
  function automatic void ref_model(input logic [N-1:0] xw, input logic [N-1:0] yw,
                                    output bit eq, output int mm, output int fd);
    logic [N-1:0] d;
    d  = xw ^ yw;
    mm = $countones(d);
    eq = (mm == 0);
    fd = 0;
    for (int i = N - 1; i >= 0; i--) if (d[i]) fd = i;
  endfunction

  // Runs one full word starting at a falling edge with the DUT in IDLE.
  task automatic run_word(input vec_t v);
    bit run_ok  = 1'b1;
    bit hold_ok = 1'b1;
    @(negedge clk);
    check({v.name, " idle in_ready"}, in_ready, 0);
    check({v.name, " idle busy"}, busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v.gaps && i > 0) begin
        in_valid = 1'b0;
        x = 1'($urandom);
        y = 1'($urandom);
        @(negedge clk);
      end
      if (!(in_ready === 1'b1 && busy === 1'b1 && done === 1'b0)) run_ok = 1'b0;
      if (equal !== hold_eq || mismatches !== CW'(hold_mm) ||
          first_diff !== IW'(hold_fd)) hold_ok = 1'b0;
      in_valid = 1'b1;
      x        = v.xw[i];
      y        = v.yw[i];
      start    = (i == v.start_at);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    x = 1'($urandom);
    y = 1'($urandom);
    check({v.name, " run flags"}, run_ok, 1);
    check({v.name, " results held in run"}, hold_ok, 1);
    check({v.name, " done"}, done, 1);
    check({v.name, " done in_ready"}, in_ready, 0);
    check({v.name, " done busy"}, busy, 0);
    check({v.name, " equal"}, equal, v.exp_eq);
    check({v.name, " mismatches"}, mismatches, v.exp_mm);
    check({v.name, " first_diff"}, first_diff, v.exp_fd);
    hold_eq = v.exp_eq;
    hold_mm = v.exp_mm;
    hold_fd = v.exp_fd;
    @(negedge clk);
    check({v.name, " done pulse width"}, done, 0);
    check({v.name, " equal held in idle"}, equal, hold_eq);
    check({v.name, " mismatches held in idle"}, mismatches, hold_mm);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t rv;
    bit   quiet_ok;

    vecs[0] = '{"a5_a5",      8'hA5, 8'hA5, 1'b0, -1, 1'b1, 0, 0};
    vecs[1] = '{"00_ff",      8'h00, 8'hFF, 1'b0, -1, 1'b0, 8, 0};
    vecs[2] = '{"10_00",      8'h10, 8'h00, 1'b0, -1, 1'b0, 1, 4};
    vecs[3] = '{"a5_a5_gaps", 8'hA5, 8'hA5, 1'b1, -1, 1'b1, 0, 0};
    vecs[4] = '{"start_in_run", 8'h01, 8'h03, 1'b0, 3, 1'b0, 1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset equal", equal, 0);
    check("reset mismatches", mismatches, 0);
    check("reset first_diff", first_diff, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) run_word(vecs[k]);

    // Reset after four accepted beats aborts the word.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x = 1'b1;
      y = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort equal", equal, 0);
    check("abort mismatches", mismatches, 0);
    check("abort first_diff", first_diff, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    hold_eq = 1'b0;
    hold_mm = 0;
    hold_fd = 0;
    quiet_ok = 1'b1;
    repeat (N + 2) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    in_valid = 1'b0;
    check("abort no done", quiet_ok, 1);
    rv = '{"after_abort", 8'h3C, 8'h3C, 1'b0, -1, 1'b1, 0, 0};
    run_word(rv);

    // Random words against the reference model.
    for (int n = 0; n < 40; n++) begin
      rv.name     = $sformatf("rand%0d", n);
      rv.xw       = N'($urandom);
      rv.yw       = ($urandom_range(0, 3) == 0) ? rv.xw : N'($urandom);
      rv.gaps     = 1'($urandom_range(0, 1));
      rv.start_at = $urandom_range(0, 2 * N);
      ref_model(rv.xw, rv.yw, rv.exp_eq, rv.exp_mm, rv.exp_fd);
      run_word(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
